// File: rtl/ex_muldiv_unit_pkg.sv
// rtl/ex_muldiv_unit_pkg.sv - shared encodings and FSM states for the RV32M multiply/divide engine
package ex_muldiv_unit_pkg;

    localparam logic [6:0] RV_OPCODE_OP = 7'b0110011;
    localparam logic [6:0] RV_FUNC7_M   = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_FIX,
        ST_DONE
    } state_t;

    function automatic logic rs1_is_signed(input logic [2:0] f3);
        return f3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] f3);
        return !(f3 inside {F3_MULHSU, F3_MULHU, F3_DIVU, F3_REMU});
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_core.sv
// rtl/ex_muldiv_unit_core.sv - one-bit-per-cycle shift-add multiply / restoring divide datapath on magnitudes
module ex_muldiv_unit_core #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           i_rst,
    input  logic           load,
    input  logic           step,
    input  logic           is_div,
    input  logic [W-1:0]   a_mag,
    input  logic [W-1:0]   b_mag,
    output logic [2*W-1:0] acc
);

    logic [W-1:0] opb;
    logic [W-1:0] addend;
    logic [W:0]   add_sum;
    logic [W:0]   rem_shift;
    logic [W:0]   sub_diff;

    // Multiply: acc = {partial_hi, multiplier}, shifted right each step.
    // Divide:   acc = {remainder, dividend/quotient}, shifted left each step.
    always_comb begin
        addend    = acc[0] ? opb : {W{1'b0}};
        add_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, addend};
        rem_shift = {acc[2*W-1:W], acc[W-1]};
        sub_diff  = rem_shift - {1'b0, opb};
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            acc <= '0;
            opb <= '0;
        end else if (load) begin
            acc <= {{W{1'b0}}, a_mag};
            opb <= b_mag;
        end else if (step) begin
            if (is_div) begin
                if (!sub_diff[W])
                    acc <= {sub_diff[W-1:0], acc[W-2:0], 1'b1};
                else
                    acc <= {rem_shift[W-1:0], acc[W-2:0], 1'b0};
            end else begin
                acc <= {add_sum, acc[W-1:1]};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit with pipeline stall control
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter logic [6:0] OPCODE_OP  = RV_OPCODE_OP,
    parameter logic [6:0] FUNC7_M    = RV_FUNC7_M
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [6:0]            i_opcode,
    input  logic [2:0]            i_func3,
    input  logic [6:0]            i_func7,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    input  logic [4:0]            i_rd_addr,
    input  logic                  i_pipe_en,
    input  logic                  i_flush,
    output logic                  o_stall,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic [4:0]            o_rd_addr
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

    state_t state, state_nxt;

    logic [CW-1:0] cnt;
    logic [2:0]    op_q;
    logic          sa_q, sb_q, dz_q, ovf_q;
    logic [4:0]    rd_q;

    logic          is_m, start, special, in_sa, in_sb;
    logic [W-1:0]  a_mag, b_mag;
    logic          core_load, core_step;
    logic [2*W-1:0] acc;

    logic [2*W-1:0] prod;
    logic [W-1:0]   mul_res, quot, rem, div_res, fix_result;

    assign is_m  = (i_opcode == OPCODE_OP) && (i_func7 == FUNC7_M);
    assign start = (state == ST_IDLE) && is_m && !i_flush;
    assign in_sa = rs1_is_signed(i_func3) && i_rs1_data[W-1];
    assign in_sb = rs2_is_signed(i_func3) && i_rs2_data[W-1];
    assign a_mag = in_sa ? -i_rs1_data : i_rs1_data;
    assign b_mag = in_sb ? -i_rs2_data : i_rs2_data;

    // Divide-by-zero and signed overflow skip iteration and resolve in FIX.
    assign special = i_func3[2] &&
                     ((i_rs2_data == '0) ||
                      (!i_func3[0] && i_rs1_data == MIN_NEG && i_rs2_data == ALL_ONES));

    ex_muldiv_unit_core #(.W(W)) u_core (
        .clk    (clk),
        .i_rst  (i_rst),
        .load   (core_load),
        .step   (core_step),
        .is_div (op_q[2]),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .acc    (acc)
    );

    always_ff @(posedge clk) begin
        if (i_rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = special ? ST_FIX : ST_BUSY;
            ST_BUSY: if (cnt == CW'(W-1)) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: if (i_pipe_en) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (i_flush)
            state_nxt = ST_IDLE;
    end

    always_comb begin
        o_stall   = !i_flush && ((state == ST_IDLE && is_m) ||
                                 state == ST_BUSY || state == ST_FIX);
        core_load = start;
        core_step = (state == ST_BUSY) && !i_flush;
    end

    // In the special cases the core was loaded but never stepped, so acc[W-1:0] still holds |rs1|.
    always_comb begin
        prod    = (sa_q ^ sb_q) ? -acc : acc;
        mul_res = (op_q == F3_MUL) ? prod[W-1:0] : prod[2*W-1:W];
        quot    = (sa_q ^ sb_q) ? -acc[W-1:0] : acc[W-1:0];
        rem     = sa_q ? -acc[2*W-1:W] : acc[2*W-1:W];
        if (dz_q) begin
            quot = ALL_ONES;
            rem  = sa_q ? -acc[W-1:0] : acc[W-1:0];
        end else if (ovf_q) begin
            quot = MIN_NEG;
            rem  = '0;
        end
        div_res    = op_q[1] ? rem : quot;
        fix_result = op_q[2] ? div_res : mul_res;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            cnt       <= '0;
            op_q      <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            rd_q      <= '0;
            o_valid   <= 1'b0;
            o_result  <= '0;
            o_rd_addr <= '0;
        end else if (i_flush) begin
            cnt     <= '0;
            o_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= i_func3;
                        sa_q  <= in_sa;
                        sb_q  <= in_sb;
                        dz_q  <= i_func3[2] && (i_rs2_data == '0);
                        ovf_q <= special && (i_rs2_data != '0);
                        rd_q  <= i_rd_addr;
                        cnt   <= '0;
                    end
                end
                ST_BUSY: cnt <= cnt + 1'b1;
                ST_FIX: begin
                    o_result  <= fix_result;
                    o_rd_addr <= rd_q;
                    o_valid   <= 1'b1;
                end
                ST_DONE: if (i_pipe_en) o_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed scoreboard bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [6:0]  i_opcode;
    logic [2:0]  i_func3;
    logic [6:0]  i_func7;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic [4:0]  i_rd_addr;
    logic        i_pipe_en;
    logic        i_flush;
    logic        o_stall;
    logic        o_valid;
    logic [31:0] o_result;
    logic [4:0]  o_rd_addr;

    int errors = 0;
    int checks = 0;
    logic [36:0] exp_q[$];
    logic valid_d = 1'b0;

    ex_muldiv_unit dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_opcode   (i_opcode),
        .i_func3    (i_func3),
        .i_func7    (i_func7),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .i_rd_addr  (i_rd_addr),
        .i_pipe_en  (i_pipe_en),
        .i_flush    (i_flush),
        .o_stall    (o_stall),
        .o_valid    (o_valid),
        .o_result   (o_result),
        .o_rd_addr  (o_rd_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every new finished result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (o_valid && !valid_d) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got 0x%08h rd %0d, nothing expected", o_result, o_rd_addr);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("result", o_result, e[31:0]);
                check("rd_addr", {27'b0, o_rd_addr}, {27'b0, e[36:32]});
            end
        end
        valid_d = o_valid;
    end

    task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        i_opcode   = 7'b0110011;
        i_func7    = 7'b0000001;
        i_func3    = f3;
        i_rs1_data = a;
        i_rs2_data = b;
        i_rd_addr  = rd;
    endtask

    task automatic drive_nop();
        i_opcode   = 7'b0010011;
        i_func7    = 7'b0000000;
        i_func3    = 3'd0;
        i_rs1_data = 32'h1234_5678;
        i_rs2_data = 32'h0000_0001;
        i_rd_addr  = 5'd0;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res,
                          input int exp_stall, input int hold);
        int n;
        exp_q.push_back({rd, exp_res});
        @(negedge clk);
        drive_op(f3, a, b, rd);
        #1;
        n = 0;
        while (o_stall && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("stall_cycles", 32'(n), 32'(exp_stall));
        check("valid_after_stall", {31'b0, o_valid}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            check("hold_valid", {31'b0, o_valid}, 32'd1);
            check("hold_no_stall", {31'b0, o_stall}, 32'd0);
        end
        i_pipe_en = 1'b1;
        drive_nop();
        @(posedge clk);
        #1;
        i_pipe_en = 1'b0;
        @(negedge clk);
        check("retired_valid", {31'b0, o_valid}, 32'd0);
    endtask

    initial begin
        i_rst     = 1'b1;
        i_pipe_en = 1'b0;
        i_flush   = 1'b0;
        drive_nop();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_result", o_result, 32'd0);
        check("rst_rd", {27'b0, o_rd_addr}, 32'd0);
        check("rst_stall", {31'b0, o_stall}, 32'd0);
        i_rst = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 34, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 34, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 34, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'hFFFF_FFFF, 34, 0);
        run_op(3'd5, 32'd100, 32'd7, 5'd5, 32'd14, 34, 0);
        run_op(3'd7, 32'd100, 32'd7, 5'd6, 32'd2, 34, 0);
        run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd7, 32'hFFFF_FFF2, 34, 0);
        run_op(3'd6, 32'hFFFF_FF9C, 32'd7, 5'd8, 32'hFFFF_FFFE, 34, 0);
        run_op(3'd4, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 2, 0);
        run_op(3'd6, 32'd5, 32'd0, 5'd10, 32'd5, 2, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 2, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 2, 0);
        run_op(3'd0, 32'd6, 32'd9, 5'd13, 32'd54, 34, 5);

        // Non-M ADD on the OP opcode never stalls.
        @(negedge clk);
        i_opcode = 7'b0110011;
        i_func7  = 7'b0000000;
        i_func3  = 3'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("add_no_stall", {31'b0, o_stall}, 32'd0);
            check("add_no_valid", {31'b0, o_valid}, 32'd0);
            @(negedge clk);
        end
        drive_nop();

        // Reset in the 10th BUSY cycle.
        @(negedge clk);
        drive_op(3'd5, 32'd1000, 32'd3, 5'd20);
        repeat (10) @(posedge clk);
        @(negedge clk);
        i_rst = 1'b1;
        drive_nop();
        @(negedge clk);
        #1;
        check("midrst_valid", {31'b0, o_valid}, 32'd0);
        check("midrst_result", o_result, 32'd0);
        check("midrst_stall", {31'b0, o_stall}, 32'd0);
        i_rst = 1'b0;

        // Flush while in FIX (divide by zero reaches FIX one cycle after start).
        @(negedge clk);
        drive_op(3'd4, 32'd9, 32'd0, 5'd21);
        @(negedge clk);
        i_flush = 1'b1;
        drive_nop();
        #1;
        check("flush_fix_stall", {31'b0, o_stall}, 32'd0);
        @(negedge clk);
        i_flush = 1'b0;
        #1;
        check("flush_fix_valid", {31'b0, o_valid}, 32'd0);
        repeat (3) @(negedge clk);
        check("flush_fix_valid_later", {31'b0, o_valid}, 32'd0);

        // Flush together with a start wins.
        @(negedge clk);
        drive_op(3'd0, 32'd3, 32'd3, 5'd22);
        i_flush = 1'b1;
        #1;
        check("flush_start_stall", {31'b0, o_stall}, 32'd0);
        @(negedge clk);
        i_flush = 1'b0;
        drive_nop();
        #1;
        check("flush_start_idle_stall", {31'b0, o_stall}, 32'd0);
        check("flush_start_valid", {31'b0, o_valid}, 32'd0);

        run_op(3'd7, 32'd17, 32'd5, 5'd23, 32'd2, 34, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
